serial_pattern_gen: RTL

Serial bit-pattern transmitter. It is the source end of the single-bit serial stream consumed by the team's Mealy sequence detectors. On a start request it latches a PAT_W-bit pattern, a repeat count and an inter-pattern gap length. It then shifts the pattern out MSB-first, one bit per clock, the requested number of times, inserting zero bits between repetitions. It is used to generate overlapping and non-overlapping stimulus for the detectors.

---
 rtl/serial_pattern_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first a
// requested number of times, with zero-filled gaps between repetitions.
module serial_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clck,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_d, out_valid_d, busy_d, done_d;

  always_ff @(posedge clck) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      idx_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
      idx_q     <= idx_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    rem_d       = rem_q;
    gap_d       = gap_q;
    gcnt_d      = gcnt_q;
    idx_d       = idx_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d = pattern;
          rem_d = repeats;
          gap_d = gap;
          idx_d = IDX_TOP;
          state_d = (repeats != '0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        if (idx_q == '0) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            rem_d   = rem_q - CNT_W'(1);
            idx_d   = IDX_TOP;
            gcnt_d  = gap_q;
            state_d = (gap_q != '0) ? S_GAP : S_SEND;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_GAP: begin
        // gcnt counts the gap cycles still to emit, including this one
        if (gcnt_q == GAP_W'(1)) state_d = S_SEND;
        else                     gcnt_d  = gcnt_q - GAP_W'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state
    unique case (state_d)
      S_SEND: begin
        out_d       = pat_d[idx_d];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_GAP: begin
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

endmodule
